auth_attempt_ctrl: RTL and testbench
====================================

# auth_attempt_ctrl

Attempt-control stage sitting directly downstream of the 8-bit setter/guesser comparator. It consumes one match/mismatch verdict per guess, counts consecutive failures, and grants an unlocked state on a match. After too many failures it enforces a timed lockout, during which further verdicts are refused. It is the only block that turns comparator results into a lock/unlock decision.

## Interface
- MAX_FAILS, 3: consecutive mismatches that trigger lockout; legal 1..15
- LOCK_CYCLES, 16: lockout duration in clk cycles; legal 1..65535
- RELOCK_CYCLES, 32: idle cycles in UNLOCKED before auto-relock (used only with AUTH_RELOCK_TIMEOUT_EN); legal 1..65535

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmp_valid  in  1  one-cycle strobe: comparator verdict present
- cmp_matched  in  1  verdict, sampled only with cmp_valid; 1 = codes equal, 0 = mismatch
- relock  in  1  request to return from UNLOCKED to ARMED
- cmp_ready  out  1  high only in ARMED; verdicts while low are discarded
- unlocked  out  1  high in UNLOCKED
- locked_out  out  1  high in LOCKOUT
- grant  out  1  one-cycle pulse on accepted match
- deny  out  1  one-cycle pulse on accepted mismatch
- timeout  out  1  one-cycle pulse on auto-relock; constant 0 without macro
- fail_count  out  4  consecutive accepted mismatches since last clear
- lock_remaining  out  16  lockout cycles left; 0 outside LOCKOUT

## Operation
- States: ARMED, UNLOCKED, LOCKOUT. All outputs are registered.
- Reset (rst_n low, asynchronous): state ARMED, cmp_ready=1, all other outputs 0. The idle counter clears.
- Accept = cmp_valid & cmp_ready at a rising edge.
- ARMED, accepted match: go to UNLOCKED, grant=1, fail_count := 0.
- ARMED, accepted mismatch, fail_count+1 < MAX_FAILS: stay ARMED, deny=1, fail_count += 1.
- ARMED, accepted mismatch, fail_count+1 == MAX_FAILS: go to LOCKOUT, deny=1, fail_count := MAX_FAILS, lock_remaining := LOCK_CYCLES.
- LOCKOUT: lock_remaining decrements once per cycle. On the edge where it equals 1: go to ARMED, lock_remaining := 0, fail_count := 0. Verdicts are ignored; relock is ignored.
- UNLOCKED: relock high at an edge: go to ARMED, fail_count stays 0. Verdicts are ignored.
- relock in ARMED or LOCKOUT has no effect.
- grant, deny and timeout are never high in the same cycle.
- fail_count saturates at MAX_FAILS and never wraps.

## Timing
- Verdict accepted at edge N: grant or deny is high for exactly cycle N..N+1, and the state and output changes are visible from the same edge.
- cmp_ready drops in the cycle after an accepted match or locking mismatch. A cmp_valid on the following cycle is dropped.
- Lockout entered at edge N: locked_out is high for exactly LOCK_CYCLES cycles, and cmp_ready returns at edge N+LOCK_CYCLES.
- relock at edge N: cmp_ready=1 from edge N.
- Reset mid-lockout or mid-unlock: immediate return to ARMED with counters cleared. There is no pulse on reset release.

## Configuration
- AUTH_RELOCK_TIMEOUT_EN defined: a 16-bit idle counter runs in UNLOCKED. It clears on entry and on relock, and increments each cycle. When it reaches RELOCK_CYCLES, the state returns to ARMED and timeout pulses for one cycle. UNLOCKED therefore lasts at most RELOCK_CYCLES cycles. A relock in the same cycle wins, so there is no timeout pulse.
- Undefined: no idle counter, timeout tied 0, and UNLOCKED persists until relock or reset.

## Test plan
- Reset, then one accepted match: grant pulses one cycle, unlocked=1, cmp_ready=0, fail_count=0.
- Two mismatches, then a match (MAX_FAILS=3): deny pulses twice, fail_count 1 then 2, then grant and fail_count=0.
- Three mismatches: locked_out=1, lock_remaining=16 counting to 0, then ARMED after exactly 16 cycles. A verdict injected mid-lockout is ignored and fail_count=0 afterwards.
- UNLOCKED, toggle cmp_valid with both verdicts: no pulses. relock: cmp_ready=1 on the next edge.
- rst_n low during lockout (lock_remaining=9): all outputs at reset values immediately, and normal operation on release.
- With AUTH_RELOCK_TIMEOUT_EN and RELOCK_CYCLES=32: match, then no relock. timeout pulses and ARMED is reached 32 cycles later. Repeat with relock at cycle 32: no timeout.

Source files
------------

// File: rtl/auth_attempt_ctrl.sv
// Attempt controller behind the code comparator: counts consecutive mismatches, unlocks on a match,
// enforces a timed lockout. Define AUTH_RELOCK_TIMEOUT_EN to auto-relock after RELOCK_CYCLES idle cycles.
module auth_attempt_ctrl #(
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned LOCK_CYCLES   = 16,
  parameter int unsigned RELOCK_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmp_valid,
  input  logic        cmp_matched,
  input  logic        relock,
  output logic        cmp_ready,
  output logic        unlocked,
  output logic        locked_out,
  output logic        grant,
  output logic        deny,
  output logic        timeout,
  output logic [3:0]  fail_count,
  output logic [15:0] lock_remaining
);

  if (MAX_FAILS < 1 || MAX_FAILS > 15 || LOCK_CYCLES < 1 || LOCK_CYCLES > 65535 ||
      RELOCK_CYCLES < 1 || RELOCK_CYCLES > 65535) begin : g_bad_params
    $error("auth_attempt_ctrl: parameter out of legal range");
  end

  localparam logic [4:0]  MAX_FAILS_W   = 5'(MAX_FAILS);
  localparam logic [3:0]  MAX_FAILS_L   = 4'(MAX_FAILS);
  localparam logic [15:0] LOCK_CYCLES_L = 16'(LOCK_CYCLES);

  typedef enum logic [1:0] {ST_ARMED, ST_UNLOCKED, ST_LOCKOUT} state_t;

  state_t state_reg;
  logic   accept;

  // cmp_ready is high only in ARMED, so accept already implies the ARMED state
  assign accept = cmp_valid & cmp_ready;

`ifdef AUTH_RELOCK_TIMEOUT_EN
  localparam logic [15:0] RELOCK_CYCLES_L = 16'(RELOCK_CYCLES);
  logic [15:0] idle_cnt_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_ARMED;
      cmp_ready      <= 1'b1;
      unlocked       <= 1'b0;
      locked_out     <= 1'b0;
      grant          <= 1'b0;
      deny           <= 1'b0;
      timeout        <= 1'b0;
      fail_count     <= 4'd0;
      lock_remaining <= 16'd0;
`ifdef AUTH_RELOCK_TIMEOUT_EN
      idle_cnt_reg   <= 16'd0;
`endif
    end else begin
      grant   <= 1'b0;
      deny    <= 1'b0;
      timeout <= 1'b0;
      case (state_reg)
        ST_ARMED: begin
          if (accept) begin
            if (cmp_matched) begin
              state_reg  <= ST_UNLOCKED;
              cmp_ready  <= 1'b0;
              unlocked   <= 1'b1;
              grant      <= 1'b1;
              fail_count <= 4'd0;
`ifdef AUTH_RELOCK_TIMEOUT_EN
              idle_cnt_reg <= 16'd0;
`endif
            end else if ({1'b0, fail_count} + 5'd1 >= MAX_FAILS_W) begin
              state_reg      <= ST_LOCKOUT;
              cmp_ready      <= 1'b0;
              locked_out     <= 1'b1;
              deny           <= 1'b1;
              fail_count     <= MAX_FAILS_L;
              lock_remaining <= LOCK_CYCLES_L;
            end else begin
              deny       <= 1'b1;
              fail_count <= fail_count + 4'd1;
            end
          end
        end
        ST_LOCKOUT: begin
          // The last lockout cycle is the one where lock_remaining reads 1
          if (lock_remaining <= 16'd1) begin
            state_reg      <= ST_ARMED;
            cmp_ready      <= 1'b1;
            locked_out     <= 1'b0;
            lock_remaining <= 16'd0;
            fail_count     <= 4'd0;
          end else begin
            lock_remaining <= lock_remaining - 16'd1;
          end
        end
        ST_UNLOCKED: begin
          if (relock) begin
            state_reg <= ST_ARMED;
            cmp_ready <= 1'b1;
            unlocked  <= 1'b0;
`ifdef AUTH_RELOCK_TIMEOUT_EN
            idle_cnt_reg <= 16'd0;
          end else if (idle_cnt_reg + 16'd1 == RELOCK_CYCLES_L) begin
            state_reg    <= ST_ARMED;
            cmp_ready    <= 1'b1;
            unlocked     <= 1'b0;
            timeout      <= 1'b1;
            idle_cnt_reg <= 16'd0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 16'd1;
`endif
          end
        end
        default: begin
          state_reg      <= ST_ARMED;
          cmp_ready      <= 1'b1;
          unlocked       <= 1'b0;
          locked_out     <= 1'b0;
          fail_count     <= 4'd0;
          lock_remaining <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auth_attempt_ctrl.sv
// Randomised and directed bench for auth_attempt_ctrl against a deadline-based reference model.
module tb_auth_attempt_ctrl;

  localparam int MAXF   = 3;
  localparam int LOCKC  = 16;
  localparam int RELOCK = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmp_valid = 1'b0;
  logic        cmp_matched = 1'b0;
  logic        relock = 1'b0;
  logic        cmp_ready, unlocked, locked_out, grant, deny, timeout;
  logic [3:0]  fail_count;
  logic [15:0] lock_remaining;

  auth_attempt_ctrl #(.MAX_FAILS(MAXF), .LOCK_CYCLES(LOCKC), .RELOCK_CYCLES(RELOCK)) dut (
    .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid), .cmp_matched(cmp_matched), .relock(relock),
    .cmp_ready(cmp_ready), .unlocked(unlocked), .locked_out(locked_out), .grant(grant),
    .deny(deny), .timeout(timeout), .fail_count(fail_count), .lock_remaining(lock_remaining)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Model: mode 0=armed 1=unlocked 2=lockout; lockout and unlock are tracked by absolute cycle stamps
  int cyc = 0;
  int mode = 0;
  int fails = 0;
  int lock_end = 0;
  int unlock_start = 0;
  bit e_grant = 0, e_deny = 0, e_timeout = 0;

  task automatic model_reset();
    mode = 0; fails = 0; e_grant = 0; e_deny = 0; e_timeout = 0;
  endtask

  task automatic model_edge(input bit v, input bit m, input bit r);
    cyc++;
    e_grant = 0; e_deny = 0; e_timeout = 0;
    if (mode == 0) begin
      if (v && m) begin
        mode = 1; e_grant = 1; fails = 0; unlock_start = cyc;
      end else if (v) begin
        fails++; e_deny = 1;
        if (fails == MAXF) begin
          mode = 2; lock_end = cyc + LOCKC;
        end
      end
    end else if (mode == 2) begin
      if (cyc == lock_end) begin
        mode = 0; fails = 0;
      end
    end else begin
      if (r) mode = 0;
`ifdef AUTH_RELOCK_TIMEOUT_EN
      else if (cyc - unlock_start == RELOCK) begin
        mode = 0; e_timeout = 1;
      end
`endif
    end
  endtask

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cmp_ready"},  16'(cmp_ready),  16'(mode == 0));
    check({tag, ".unlocked"},   16'(unlocked),   16'(mode == 1));
    check({tag, ".locked_out"}, 16'(locked_out), 16'(mode == 2));
    check({tag, ".grant"},      16'(grant),      16'(e_grant));
    check({tag, ".deny"},       16'(deny),       16'(e_deny));
    check({tag, ".timeout"},    16'(timeout),    16'(e_timeout));
    check({tag, ".fail_count"}, 16'(fail_count), 16'(fails));
    check({tag, ".lock_rem"},   lock_remaining,  16'((mode == 2) ? (lock_end - cyc) : 0));
  endtask

  // Called at a negedge: drive, let one rising edge pass, compare at the next negedge
  task automatic step(input string tag, input bit v, input bit m, input bit r);
    cmp_valid = v; cmp_matched = m; relock = r;
    @(posedge clk);
    model_edge(v, m, r);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    cmp_valid = 0; cmp_matched = 0; relock = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".in_reset"});
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all({tag, ".released"});
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    do_reset("reset");

    // Single match, then relock
    step("match", 1, 1, 0);
    step("after_grant", 1, 0, 0);
    step("relock", 0, 0, 1);

    // Two mismatches, then a match
    step("mm1", 1, 0, 0);
    step("mm2", 1, 0, 0);
    step("mm_match", 1, 1, 0);
    step("relock2", 0, 0, 1);

    // Lockout with a verdict injected mid-way
    for (int i = 0; i < 3; i++) step("lock_mm", 1, 0, 0);
    check("lock_start_rem", lock_remaining, 16'd16);
    for (int i = 1; i < LOCKC; i++) step("lock_run", (i == 5), (i == 5), (i == 6));
    check("lock_last_ready", 16'(cmp_ready), 16'd0);
    step("lock_exit", 0, 0, 0);
    check("lock_exit_fails", 16'(fail_count), 16'd0);

    // Verdicts ignored while unlocked
    step("unl_match", 1, 1, 0);
    for (int i = 0; i < 4; i++) step("unl_toggle", i[0], i[1], 0);
    step("unl_relock", 0, 0, 1);

    // Reset mid-lockout with 9 cycles left
    for (int i = 0; i < 3; i++) step("rlock_mm", 1, 0, 0);
    for (int i = 0; i < 7; i++) step("rlock_run", 0, 0, 0);
    check("rlock_rem9", lock_remaining, 16'd9);
    do_reset("mid_lock_reset");
    step("post_reset_match", 1, 1, 0);
    step("post_reset_relock", 0, 0, 1);

`ifdef AUTH_RELOCK_TIMEOUT_EN
    step("to_match", 1, 1, 0);
    for (int i = 0; i < RELOCK; i++) step("to_idle", 0, 0, 0);
    check("to_armed", 16'(cmp_ready), 16'd1);
    step("to_match2", 1, 1, 0);
    for (int i = 1; i < RELOCK; i++) step("to_idle2", 0, 0, 0);
    step("to_relock_wins", 0, 0, 1);
`endif

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        do_reset("rand_reset");
      end else begin
        step("rand",
             ($urandom_range(99) < 45),
             ($urandom_range(99) < 30),
             ($urandom_range(99) < 8));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
